// File: rtl/qam_carrier_loop.sv
// qam_carrier_loop
//   Carrier-recovery loop core for the QAM demodulator. A registered phase
//   detector feeds a PI loop filter whose proportional/integral right-shifts
//   are switched by an acquisition / tracking / locked state machine. The
//   filter output steers a free-running phase accumulator that addresses the
//   external sin/cos LUT.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : yi/yq sample strobe
//   yi, yq     : signed DW-bit baseband samples from the mixer/LPF
//   pd_mode    : 0 = QAM polarity detector, 1 = BPSK Costas detector
//   restart    : one-cycle pulse forcing re-acquisition
//   carrier    : nominal phase increment per clock
//   df         : signed FW-bit loop-filter output (frequency correction)
//   phase      : PW-bit phase accumulator value for the NCO LUT
//   pd         : signed DW+1-bit registered phase error
//   state      : 00 ACQ, 01 TRACK, 10 LOCKED
//   locked     : high only while in LOCKED
module qam_carrier_loop #(
  parameter int DW         = 27,
  parameter int FW         = 27,
  parameter int PW         = 32,
  parameter int KP_ACQ     = 6,
  parameter int KI_ACQ     = 12,
  parameter int KP_TRK     = 9,
  parameter int KI_TRK     = 16,
  parameter int LOCK_WIN   = 4096,
  parameter int LOCK_CNT   = 256,
  parameter int UNLOCK_CNT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] yi,
  input  logic signed [DW-1:0] yq,
  input  logic                 pd_mode,
  input  logic                 restart,
  input  logic        [PW-1:0] carrier,
  output logic signed [FW-1:0] df,
  output logic        [PW-1:0] phase,
  output logic signed [DW:0]   pd,
  output logic        [1:0]    state,
  output logic                 locked
);

  localparam int PDW  = DW + 1;
  // Arithmetic width wide enough for integrator + shifted error without overflow.
  localparam int SW   = ((FW > PDW) ? FW : PDW) + 2;
  localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam longint                 FMAXL = (longint'(1) <<< (FW - 1)) - 1;
  localparam logic signed [SW-1:0]   FMAX  = SW'(FMAXL);
  localparam logic signed [SW-1:0]   LW    = SW'(LOCK_WIN);

  typedef enum logic [1:0] {
    ACQ    = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                v1, v2;
  logic signed [FW-1:0]  integ;
  logic signed [PDW-1:0] prop;
  logic signed [PDW-1:0] yi_x, yq_x, t_q, t_i, pd_next;
  logic signed [SW-1:0]  pd_x, integ_sum, df_sum;
  logic                  in_win;
  int unsigned           ki, kp;

  // Symmetric saturation to +/-(2^(FW-1)-1).
  function automatic logic signed [FW-1:0] sat(input logic signed [SW-1:0] x);
    if (x > FMAX)
      return FW'(FMAX);
    else if (x < -FMAX)
      return FW'(-FMAX);
    else
      return FW'(x);
  endfunction

  // Phase detector: sgn(x) is +1 for x >= 0, so a sign bit selects negation.
  // DW+1 bits hold every reachable result, including -(-2^(DW-1)).
  always_comb begin
    yi_x    = {yi[DW-1], yi};
    yq_x    = {yq[DW-1], yq};
    t_q     = yi[DW-1] ? -yq_x : yq_x;
    t_i     = yq[DW-1] ? -yi_x : yi_x;
    pd_next = pd_mode ? t_q : (t_q - t_i);
  end

  always_comb begin
    ki        = (state_q == ACQ) ? KI_ACQ : KI_TRK;
    kp        = (state_q == ACQ) ? KP_ACQ : KP_TRK;
    pd_x      = SW'(pd);
    integ_sum = SW'(integ) + (pd_x >>> ki);
    df_sum    = SW'(integ) + SW'(prop);
    in_win    = (pd_x < LW) && (pd_x > -LW);
  end

  // Datapath: v1 marks a fresh pd (stage 2 due), v2 marks a pending df update.
  // The proportional term is captured at stage 2 so its gain tracks the same
  // state as the integral term of that sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      pd    <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      integ <= '0;
      prop  <= '0;
      df    <= '0;
      phase <= '0;
    end else begin
      phase <= phase + carrier + PW'(df);
      if (in_valid)
        pd <= pd_next;
      v1 <= in_valid & ~restart;
      if (restart) begin
        integ <= '0;
        df    <= '0;
        v2    <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) begin
          integ <= sat(integ_sum);
          prop  <= PDW'(pd_x >>> kp);
        end
        if (v2)
          df <= sat(df_sum);
      end
    end
  end

  // Lock state machine, evaluated once per registered pd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACQ;
      cnt_q   <= '0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      locked  <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = ACQ;
      cnt_d   = '0;
    end else if (v1) begin
      case (state_q)
        ACQ, TRACK: begin
          if (!in_win) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(LOCK_CNT - 1)) begin
            state_d = (state_q == ACQ) ? TRACK : LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (in_win) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(UNLOCK_CNT - 1)) begin
            state_d = ACQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ACQ;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_qam_carrier_loop.sv
module tb_qam_carrier_loop;

  localparam int DW         = 27;
  localparam int FW         = 27;
  localparam int PW         = 32;
  localparam int KP_ACQ     = 6;
  localparam int KI_ACQ     = 12;
  localparam int KP_TRK     = 9;
  localparam int KI_TRK     = 16;
  localparam int LOCK_WIN   = 4096;
  localparam int LOCK_CNT   = 256;
  localparam int UNLOCK_CNT = 64;

  localparam longint PDMAX = longint'(1) <<< (DW - 1);
  localparam longint FMAX  = (longint'(1) <<< (FW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] yi = '0;
  logic signed [DW-1:0] yq = '0;
  logic                 pd_mode = 1'b0;
  logic                 restart = 1'b0;
  logic        [PW-1:0] carrier = '0;
  logic signed [FW-1:0] df;
  logic        [PW-1:0] phase;
  logic signed [DW:0]   pd;
  logic        [1:0]    state;
  logic                 locked;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qam_carrier_loop #(
    .DW(DW), .FW(FW), .PW(PW),
    .KP_ACQ(KP_ACQ), .KI_ACQ(KI_ACQ), .KP_TRK(KP_TRK), .KI_TRK(KI_TRK),
    .LOCK_WIN(LOCK_WIN), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .yi(yi), .yq(yq),
    .pd_mode(pd_mode), .restart(restart), .carrier(carrier),
    .df(df), .phase(phase), .pd(pd), .state(state), .locked(locked)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sample-level) ----------------
  function automatic longint sgn(input longint x);
    return (x >= 0) ? 1 : -1;
  endfunction

  function automatic longint pd_of(input longint a, input longint b, input bit m);
    return m ? sgn(a) * b : sgn(a) * b - sgn(b) * a;
  endfunction

  function automatic longint clampf(input longint x);
    if (x > FMAX) return FMAX;
    if (x < -FMAX) return -FMAX;
    return x;
  endfunction

  typedef struct {
    longint pd;
    longint prop;
    int     age;
  } smp_t;

  smp_t   pipe[$];
  longint m_pd = 0, m_integ = 0, m_df = 0, m_phase = 0;
  int     m_state = 0, m_cnt = 0;

  task automatic lock_update(input longint p);
    bit inwin;
    inwin = (p < LOCK_WIN) && (p > -LOCK_WIN);
    if (m_state != 2) begin
      m_cnt = inwin ? m_cnt + 1 : 0;
      if (m_cnt == LOCK_CNT) begin
        m_state = m_state + 1;
        m_cnt   = 0;
      end
    end else begin
      m_cnt = inwin ? 0 : m_cnt + 1;
      if (m_cnt == UNLOCK_CNT) begin
        m_state = 0;
        m_cnt   = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pd = 0; m_integ = 0; m_df = 0; m_phase = 0; m_state = 0; m_cnt = 0;
      pipe.delete();
    end else begin
      m_phase = (m_phase + longint'(carrier) + m_df) & 64'hFFFF_FFFF;
      if (restart) begin
        pipe.delete();
        m_integ = 0; m_df = 0; m_state = 0; m_cnt = 0;
      end else begin
        foreach (pipe[i])
          if (pipe[i].age == 2) m_df = clampf(m_integ + pipe[i].prop);
        foreach (pipe[i])
          if (pipe[i].age == 1) begin
            int ki, kp;
            ki = (m_state == 0) ? KI_ACQ : KI_TRK;
            kp = (m_state == 0) ? KP_ACQ : KP_TRK;
            m_integ      = clampf(m_integ + (pipe[i].pd >>> ki));
            pipe[i].prop = pipe[i].pd >>> kp;
            lock_update(pipe[i].pd);
          end
      end
      foreach (pipe[i]) pipe[i].age++;
      while (pipe.size() > 0 && pipe[0].age > 2) void'(pipe.pop_front());
      if (in_valid) begin
        m_pd = pd_of(longint'(yi), longint'(yq), pd_mode);
        if (!restart) pipe.push_back('{m_pd, 0, 1});
      end
    end
  end

  // Every cycle, compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    chk("model_pd", longint'(pd), m_pd);
    chk("model_df", longint'(df), m_df);
    chk("model_phase", longint'(phase), m_phase);
    chk("model_state", longint'(state), longint'(m_state));
    chk("model_locked", longint'(locked), longint'(m_state == 2));
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input longint a, input longint b,
                      input bit m, input bit rs);
    in_valid = v;
    yi       = DW'(a);
    yq       = DW'(b);
    pd_mode  = m;
    restart  = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
  endtask

  typedef struct {
    longint a;
    longint b;
    bit     m;
    longint exp_pd;
  } vec_t;

  initial begin
    vec_t   vecs[8];
    longint p0;

    vecs[0] = '{100, -50, 1'b0, 50};
    vecs[1] = '{100, -50, 1'b1, -50};
    vecs[2] = '{-PDMAX, -PDMAX, 1'b0, 0};
    vecs[3] = '{-PDMAX, -PDMAX, 1'b1, PDMAX};
    vecs[4] = '{0, 5, 1'b0, 5};
    vecs[5] = '{-7, 3, 1'b0, 4};
    vecs[6] = '{PDMAX - 1, -PDMAX, 1'b0, -1};
    vecs[7] = '{-1, 0, 1'b1, 0};

    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of activity.
    carrier = 32'd123;
    repeat (5) step(1'b1, 700, -300, 1'b0, 1'b0);
    do_reset();
    chk("rst_df", longint'(df), 0);
    chk("rst_phase", longint'(phase), 0);
    chk("rst_pd", longint'(pd), 0);
    chk("rst_state", longint'(state), 0);
    chk("rst_locked", longint'(locked), 0);

    // Phase detector table.
    carrier = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].m, 1'b0);
      chk($sformatf("pd_vec%0d", i), longint'(pd), vecs[i].exp_pd);
    end

    // Single-sample loop gain in ACQ: integ = 4096>>12 = 1, df = 1 + 4096>>6.
    do_reset();
    step(1'b1, 1, 4096, 1'b1, 1'b0);
    chk("gain_pd", longint'(pd), 4096);
    idle();
    chk("gain_df_latency", longint'(df), 0);
    idle();
    chk("gain_df", longint'(df), 65);

    // Phase wrap with half-turn increment.
    carrier = 32'h8000_0000;
    do_reset();
    chk("wrap_p0", longint'(phase), 0);
    idle();
    chk("wrap_p1", longint'(phase), 64'h8000_0000);
    idle();
    chk("wrap_p2", longint'(phase), 0);

    // Lock progression.
    carrier = '0;
    do_reset();
    repeat (LOCK_CNT) step(1'b1, 1000, 0, 1'b1, 1'b0);
    chk("lock_acq_255", longint'(state), 0);
    step(1'b1, 1000, 0, 1'b1, 1'b0);
    chk("lock_track", longint'(state), 1);
    repeat (LOCK_CNT - 1) step(1'b1, 1000, 0, 1'b1, 1'b0);
    chk("lock_track_511", longint'(state), 1);
    idle();
    chk("lock_locked", longint'(state), 2);
    chk("lock_locked_flag", longint'(locked), 1);
    repeat (UNLOCK_CNT - 1) step(1'b1, 1000, 5000, 1'b1, 1'b0);
    idle();
    chk("unlock_63", longint'(state), 2);
    step(1'b1, 1000, 5000, 1'b1, 1'b0);
    idle();
    chk("unlock_64", longint'(state), 0);
    chk("unlock_flag", longint'(locked), 0);

    // Saturation of df at +max.
    carrier = 32'd1;
    do_reset();
    repeat (4200) step(1'b1, -1, -PDMAX, 1'b1, 1'b0);
    chk("sat_df", longint'(df), FMAX);
    repeat (20) step(1'b1, -1, -PDMAX, 1'b1, 1'b0);
    chk("sat_hold", longint'(df), FMAX);
    chk("sat_pd", longint'(pd), PDMAX);

    // Restart with a simultaneous sample.
    p0 = m_phase;
    step(1'b1, 1, 100, 1'b1, 1'b1);
    chk("rs_state", longint'(state), 0);
    chk("rs_df", longint'(df), 0);
    chk("rs_pd", longint'(pd), 100);
    chk("rs_phase1", longint'(phase), (p0 + 1 + FMAX) & 64'hFFFF_FFFF);
    idle();
    chk("rs_phase2", longint'(phase), (p0 + 2 + FMAX) & 64'hFFFF_FFFF);
    idle();
    idle();
    chk("rs_df_after", longint'(df), 0);

    // Randomized traffic, checked by the model every cycle.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      longint a, b;
      bit     v, m, rs;
      if ((i % 500) == 0) carrier = $urandom;
      v  = ($urandom_range(0, 3) != 0);
      m  = (i < 2000) ? 1'b1 : 1'($urandom);
      rs = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 31) == 0) begin
        a = longint'($urandom_range(0, 32'h07FF_FFFF)) - PDMAX;
        b = longint'($urandom_range(0, 32'h07FF_FFFF)) - PDMAX;
      end else begin
        a = longint'($urandom_range(0, 6000)) - 3000;
        b = longint'($urandom_range(0, 6000)) - 3000;
      end
      step(v, a, b, m, rs);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
